// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART byte width and received-entry type
package uart_pkg;

   localparam int UART_DATA_W = 8;

   typedef struct packed {
      logic                   err;
      logic [UART_DATA_W-1:0] data;
   } rx_entry_t;

endpackage

// File: rtl/uart_edge_detect.sv
// rtl/uart_edge_detect.sv - 1-bit rising-edge detector with selectable reset value
module uart_edge_detect #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise
);

   logic din_q;
   logic din_d;

   always_comb begin
      din_d = din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         din_q <= RESET_VAL;
      end else begin
         din_q <= din_d;
      end
   end

   assign rise = din & ~din_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - FWFT receive FIFO behind Uart8; UART_RX_FIFO_DROP_ERR_EN discards errored frames
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rx_done,
   input  logic                   rx_err,
   input  logic [UART_DATA_W-1:0] rx_byte,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [UART_DATA_W-1:0] out_data,
   output logic                   out_err,
   output logic [ADDR_W:0]        count,
   output logic                   full,
   output logic                   empty,
   output logic                   overflow,
   input  logic                   overflow_clr
);

   generate
      if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
         $error("uart_rx_fifo: DEPTH must be a power of two and at least 2");
      end
   endgenerate

`ifdef UART_RX_FIFO_DROP_ERR_EN
   typedef logic [UART_DATA_W-1:0] mem_t;
`else
   typedef rx_entry_t mem_t;
`endif

   mem_t            mem_q [DEPTH];
   mem_t            wr_entry;
   mem_t            head;
   logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
   logic            overflow_q, overflow_d;
   logic            push_req;
   logic            push_ok;
   logic            push_acc;
   logic            drop;
   logic            pop;

   // Reset value 1 keeps an rx_done that is already high at reset release from pushing.
   uart_edge_detect #(
      .RESET_VAL(1'b1)
   ) u_done_edge (
      .clk (clk),
      .rst (rst),
      .din (rx_done),
      .rise(push_req)
   );

   assign empty     = (rd_ptr_q == wr_ptr_q);
   assign full      = (rd_ptr_q[ADDR_W] != wr_ptr_q[ADDR_W]) &&
                      (rd_ptr_q[ADDR_W-1:0] == wr_ptr_q[ADDR_W-1:0]);
   assign count     = wr_ptr_q - rd_ptr_q;
   assign out_valid = ~empty;
   assign overflow  = overflow_q;
   assign head      = mem_q[rd_ptr_q[ADDR_W-1:0]];

`ifdef UART_RX_FIFO_DROP_ERR_EN
   assign push_ok  = push_req & ~rx_err;
   assign wr_entry = rx_byte;
   assign out_data = head;
   assign out_err  = 1'b0;
`else
   assign push_ok  = push_req;
   assign wr_entry = '{err: rx_err, data: rx_byte};
   assign out_data = head.data;
   assign out_err  = head.err;
`endif

   always_comb begin
      pop        = out_valid & out_ready;
      push_acc   = push_ok & (~full | pop);
      drop       = push_ok & full & ~pop;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      overflow_d = overflow_q;
      if (push_acc) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      // A drop in the same cycle as a clear leaves the flag set.
      if (drop) begin
         overflow_d = 1'b1;
      end else if (overflow_clr) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_acc) begin
         mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_entry;
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo against a queue model
module tb_uart_rx_fifo;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_done;
   logic       rx_err;
   logic [7:0] rx_byte;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_err;
   logic [4:0] count;
   logic       full;
   logic       empty;
   logic       overflow;
   logic       overflow_clr;

   int n_checks = 0;
   int n_fail   = 0;

   logic [8:0] q[$];
   bit         m_prev;
   bit         m_ovf;

   uart_rx_fifo #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_done     (rx_done),
      .rx_err      (rx_err),
      .rx_byte     (rx_byte),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_err     (out_err),
      .count       (count),
      .full        (full),
      .empty       (empty),
      .overflow    (overflow),
      .overflow_clr(overflow_clr)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      q.delete();
      m_prev = 1'b1;
      m_ovf  = 1'b0;
   endtask

   // Apply the current inputs to the model, then advance one clock and settle.
   task automatic step();
      bit         push;
      bit         pop;
      bit         dropped;
      logic [8:0] e;
      pop     = out_ready && (q.size() != 0);
      push    = rx_done && !m_prev;
      m_prev  = rx_done;
      dropped = 1'b0;
`ifdef UART_RX_FIFO_DROP_ERR_EN
      if (rx_err) push = 1'b0;
      e = {1'b0, rx_byte};
`else
      e = {rx_err, rx_byte};
`endif
      if (pop) void'(q.pop_front());
      if (push) begin
         if (q.size() < DEPTH) q.push_back(e);
         else dropped = 1'b1;
      end
      if (dropped) m_ovf = 1'b1;
      else if (overflow_clr) m_ovf = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input logic err, input int hold);
      rx_byte = b;
      rx_err  = err;
      rx_done = 1'b1;
      for (int i = 0; i < hold; i++) step();
      rx_done = 1'b0;
      rx_byte = 8'($urandom);
      rx_err  = 1'($urandom);
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1; rx_done = 1'b1; rx_err = 1'b0; rx_byte = 8'h00;
      out_ready = 1'b0; overflow_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      model_reset();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if (count !== 5'(q.size()) || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_done_high: count=%0d out_valid=%b, required count=0 out_valid=0", count, out_valid);
         end
      end
      n_checks++;
      if (empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags: empty=%b full=%b overflow=%b, required 1 0 0", empty, full, overflow);
      end
      rx_byte = 8'h11;
      rx_done = 1'b0; step();
      rx_done = 1'b1; step();
      n_checks++;
      if (count !== 5'd1 || out_data !== 8'h11) begin
         n_fail++;
         $display("FAIL reset_rearm: count=%0d data=%h, required count=1 data=11", count, out_data);
      end
      rx_done = 1'b0; out_ready = 1'b1; step(); out_ready = 1'b0;
   endtask

   task automatic test_single();
      rx_byte = 8'hD6; rx_err = 1'b0; rx_done = 1'b1;
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 8'hD6 || count !== 5'd1) begin
         n_fail++;
         $display("FAIL single_first: valid=%b data=%h count=%0d, required 1 d6 1", out_valid, out_data, count);
      end
      for (int i = 0; i < 4; i++) step();
      rx_done = 1'b0; step();
      n_checks++;
      if (count !== 5'd1) begin
         n_fail++;
         $display("FAIL single_held: count=%0d, required 1", count);
      end
      out_ready = 1'b1; step(); out_ready = 1'b0;
      n_checks++;
      if (empty !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_pop: empty=%b valid=%b, required 1 0", empty, out_valid);
      end
   endtask

   task automatic test_fill_overflow();
      for (int i = 0; i < 16; i++) send(8'(i), 1'b0, 1);
      n_checks++;
      if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL fill: full=%b count=%0d ovf=%b, required 1 16 0", full, count, overflow);
      end
      send(8'hAA, 1'b0, 1);
      n_checks++;
      if (overflow !== 1'b1 || count !== 5'd16) begin
         n_fail++;
         $display("FAIL overflow_set: ovf=%b count=%0d, required 1 16", overflow, count);
      end
   endtask

   task automatic test_full_push_pop();
      logic [7:0] exp_b;
      n_checks++;
      if (out_data !== 8'h00) begin
         n_fail++;
         $display("FAIL full_head: data=%h, required 00", out_data);
      end
      rx_byte = 8'h55; rx_err = 1'b0; rx_done = 1'b1; out_ready = 1'b1;
      step();
      rx_done = 1'b0; out_ready = 1'b0;
      n_checks++;
      if (count !== 5'd16 || full !== 1'b1) begin
         n_fail++;
         $display("FAIL full_push_pop: count=%0d full=%b, required 16 1", count, full);
      end
      step();
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         exp_b = (i < 15) ? 8'(i + 1) : 8'h55;
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== exp_b) begin
            n_fail++;
            $display("FAIL drain_order[%0d]: valid=%b data=%h, required 1 %h", i, out_valid, out_data, exp_b);
         end
         step();
      end
      out_ready = 1'b0;
      n_checks++;
      if (empty !== 1'b1) begin
         n_fail++;
         $display("FAIL drain_empty: empty=%b, required 1", empty);
      end
   endtask

   task automatic test_err_frame();
      send(8'h3C, 1'b1, 2);
`ifdef UART_RX_FIFO_DROP_ERR_EN
      n_checks++;
      if (count !== 5'd0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL err_drop: count=%0d valid=%b, required 0 0", count, out_valid);
      end
`else
      n_checks++;
      if (out_data !== 8'h3C || out_err !== 1'b1 || count !== 5'd1) begin
         n_fail++;
         $display("FAIL err_store: data=%h err=%b count=%0d, required 3c 1 1", out_data, out_err, count);
      end
      out_ready = 1'b1; step(); out_ready = 1'b0;
`endif
   endtask

   task automatic test_overflow_clr();
      overflow_clr = 1'b1; step(); overflow_clr = 1'b0;
      n_checks++;
      if (overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_clr_alone: ovf=%b, required 0", overflow);
      end
      for (int i = 0; i < 16; i++) send(8'($urandom), 1'b0, 1);
      rx_byte = 8'hEE; rx_err = 1'b0; rx_done = 1'b1; overflow_clr = 1'b1;
      step();
      rx_done = 1'b0; overflow_clr = 1'b0;
      n_checks++;
      if (overflow !== 1'b1 || count !== 5'd16) begin
         n_fail++;
         $display("FAIL ovf_clr_vs_drop: ovf=%b count=%0d, required 1 16", overflow, count);
      end
      overflow_clr = 1'b1; step(); overflow_clr = 1'b0;
      n_checks++;
      if (overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_clr_next: ovf=%b, required 0", overflow);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 11; i++) begin
         n_checks++;
         if (out_data !== q[0][7:0]) begin
            n_fail++;
            $display("FAIL clr_drain[%0d]: data=%h, required %h", i, out_data, q[0][7:0]);
         end
         step();
      end
      out_ready = 1'b0;
      step();
      n_checks++;
      if (count !== 5'd5) begin
         n_fail++;
         $display("FAIL mid_drain_count: count=%0d, required 5", count);
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (count !== 5'd0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: count=%0d valid=%b, required 0 0", count, out_valid);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         rx_done      = 1'($urandom_range(0, 1));
         rx_byte      = 8'($urandom);
         rx_err       = ($urandom_range(0, 4) == 0);
         out_ready    = (c < 300) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 2) != 0);
         overflow_clr = ($urandom_range(0, 7) == 0);
         step();
         n_checks++;
         if (count !== 5'(q.size()) || out_valid !== (q.size() != 0) ||
             full !== (q.size() == DEPTH) || overflow !== m_ovf) begin
            n_fail++;
            $display("FAIL random_state[%0d]: count=%0d valid=%b full=%b ovf=%b, required %0d %b %b %b",
                     c, count, out_valid, full, overflow, q.size(), q.size() != 0, q.size() == DEPTH, m_ovf);
         end
         if (q.size() != 0) begin
            n_checks++;
            if (out_data !== q[0][7:0] || out_err !== q[0][8]) begin
               n_fail++;
               $display("FAIL random_head[%0d]: data=%h err=%b, required %h %b", c, out_data, out_err, q[0][7:0], q[0][8]);
            end
         end
      end
      rx_done = 1'b0; out_ready = 1'b0; overflow_clr = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill_overflow();
      test_full_push_pop();
      test_err_frame();
      test_overflow_clr();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
